arbitro_memoria: RTL and testbench
==================================

# arbitro_memoria

Two-port arbiter that shares the single-port synchronous memory between the CPU's REM/RDM path and a DMA/program-loader port. It performs one memory access per clock, returns read data to the requester that issued it, and lets the loader lock the memory for short bursts without starving the CPU. It sits between the CPU's memory-side signals and the memory macro.

## Interface
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- MAX_HOLD, 8: maximum consecutive locked DMA grants while cpu_req is pending; legal range 1..255.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- dma_req, dma_we, dma_addr, dma_wdata: same as the CPU inputs, DMA side
- dma_lock  in  1  request continued ownership after the current grant
- dma_gnt, dma_rvalid  out  1  DMA-side equivalents
- rdata  out  DATA_W  read data, shared by both ports; qualified by *_rvalid
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_q  in  DATA_W  memory read data, registered, 1-cycle latency

## Operation
- Grants are combinational from the current requests and the registered state. At most one grant per cycle. A granted access goes to memory in the same cycle.
- Requester rule: hold req, we, addr and wdata stable until gnt is sampled high at a rising edge. Drop req or change the request on the next cycle.
- Granted port drives mem_addr, mem_wdata and mem_we. With no grant: mem_we=0, mem_addr and mem_wdata = 0.
- Arbitration order each cycle:
  - Lock rule: last cycle granted DMA, and dma_lock=1, dma_req=1 and hold_cnt<MAX_HOLD. Result: DMA is granted.
  - Otherwise, only one request is present: that port is granted.
  - Otherwise, both requests are present: the CPU wins (fixed priority, see Configuration).
- State registers:
  - last_owner: NONE, CPU or DMA. Set to the granted port; set to NONE in a cycle with no grant.
  - hold_cnt, 8 bits:
    - Increments on every DMA grant made by the lock rule while cpu_req=1.
    - Clears on any cycle without a DMA grant.
    - Saturates at MAX_HOLD, which disables the lock rule for one arbitration.
- Read return: a granted read sets that port's rvalid on the next cycle. rdata = mem_q in that cycle. Writes never raise rvalid.
- Simultaneous events:
  - A new grant may be issued in the same cycle as the previous access's rvalid.
  - dma_lock without dma_req has no effect.

## Timing
- Reset values: cpu_gnt=0, dma_gnt=0, cpu_rvalid=0, dma_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, last_owner=NONE, hold_cnt=0. rdata follows mem_q.
- While rst=1, all grants and mem_we are forced to 0.
- Reset asserted mid-operation: any pending rvalid is discarded. It is not re-issued after reset.
- Read latency is grant at edge N, rvalid and rdata valid after edge N+1. Throughput is one access per cycle.
- Worst-case CPU wait under DMA lock is MAX_HOLD+1 cycles after cpu_req rises.

## Configuration
- ARB_RR_EN defined: round-robin on contention. A 1-bit pointer marks the port that lost the last contended arbitration. That port wins the next contention. Pointer reset value = CPU preferred.
- ARB_RR_EN undefined: fixed priority, CPU always wins contention. The pointer register is not built.
- The lock rule and MAX_HOLD behave identically in both builds.

## Structure
- Shared package holds:
  - the owner encoding (OWN_NONE=2'b00, OWN_CPU=2'b01, OWN_DMA=2'b10)
  - default ADDR_W and DATA_W
- One sub-module, arb_prioridade, is natural: combinational winner selection from the two requests, the lock qualifier and the RR pointer.
- Counters, rvalid pipeline and memory muxing stay in the top module.

## Test plan
- Reset: assert rst asynchronously mid-cycle with both req=1. Required: gnt=0, mem_we=0 and rvalid=0 immediately, and held until the rst release edge.
- CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x0010, memory[0x10]=0x1234. Required: cpu_gnt=1 in the same cycle; next cycle cpu_rvalid=1, rdata=0x1234, dma_rvalid=0.
- Contention, fixed build: both read 0x0001 and 0x0002 continuously. Required: CPU granted every cycle and DMA never. With ARB_RR_EN, grants alternate CPU, DMA, CPU, …
- Lock starvation guard: MAX_HOLD=4, DMA writes with dma_lock=1, then cpu_req rises. Required: exactly 4 further locked DMA grants, then cpu_gnt=1 on the 5th cycle after cpu_req rises.
- Write then read: DMA writes 0xBEEF to 0x0020, then CPU reads 0x0020 in the next cycle. Required: mem_we=1 only in the DMA cycle; cpu_rvalid=1 with rdata=0xBEEF one cycle after cpu_gnt.

Source files
------------

// File: rtl/arbitro_memoria_pkg.sv
// Shared definitions for the two-port memory arbiter: owner encoding and default bus widths.
package arbitro_memoria_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DMA  = 2'b10
  } owner_t;
endpackage

// File: rtl/arbitro_memoria_arb_prioridade.sv
// Combinational winner selection between CPU and DMA: lock qualifier first, then a lone
// requester, then contention resolved by rr_ptr (0 = CPU preferred, 1 = DMA preferred).
module arb_prioridade (
  input  logic cpu_req,
  input  logic dma_req,
  input  logic lock_ok,
  input  logic rr_ptr,
  output logic cpu_win,
  output logic dma_win,
  output logic contended
);
  always_comb begin
    contended = cpu_req & dma_req & ~lock_ok;
    dma_win   = lock_ok | (dma_req & ~cpu_req) | (contended & rr_ptr);
    cpu_win   = ~lock_ok & cpu_req & (~dma_req | ~rr_ptr);
  end
endmodule

// File: rtl/arbitro_memoria.sv
// Two-port arbiter sharing one synchronous memory between CPU and DMA, one access per clock.
// Optional macro ARB_RR_EN: round-robin on contention instead of fixed CPU priority.
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);
  owner_t     last_owner;
  logic [7:0] hold_cnt;
  logic       rr_ptr;
  logic       lock_ok;
  logic       cpu_win;
  logic       dma_win;
  logic       contended;

  // Lock only extends an existing DMA ownership, and only until hold_cnt saturates.
  assign lock_ok = (last_owner == OWN_DMA) && dma_lock && dma_req
                   && (hold_cnt < 8'(MAX_HOLD));

  arb_prioridade u_prio (
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .lock_ok   (lock_ok),
    .rr_ptr    (rr_ptr),
    .cpu_win   (cpu_win),
    .dma_win   (dma_win),
    .contended (contended)
  );

  assign cpu_gnt = cpu_win & ~rst;
  assign dma_gnt = dma_win & ~rst;
  assign rdata   = mem_q;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_NONE;
      hold_cnt   <= 8'd0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt)      last_owner <= OWN_CPU;
      else if (dma_gnt) last_owner <= OWN_DMA;
      else              last_owner <= OWN_NONE;
      // Only locked grants that keep a waiting CPU out count toward the hold limit.
      if (!dma_gnt)                hold_cnt <= 8'd0;
      else if (lock_ok && cpu_req) hold_cnt <= hold_cnt + 8'd1;
    end
  end

`ifdef ARB_RR_EN
  logic rr_ptr_q;
  // Pointer records the loser of the last contended arbitration; it wins next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr_q <= 1'b0;
    else if (contended) rr_ptr_q <= cpu_win;
  end
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif
endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria with MAX_HOLD=4 and a 1-cycle registered memory model.
module tb_arbitro_memoria;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_q;
  logic [15:0] mem [0:255];

  typedef struct {
    bit          is_dma;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  arbitro_memoria #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_q <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One arbitration cycle: checks grants and memory-side drive, queues expected read data.
  task automatic step(input bit eg_cpu, input bit eg_dma, input logic [15:0] ea,
                      input logic [15:0] erd, input string nm);
    bit          ewe;
    logic [15:0] ewd;
    exp_t        e;
    @(negedge clk);
    ewe = (eg_cpu && cpu_we) || (eg_dma && dma_we);
    ewd = eg_cpu ? cpu_wdata : (eg_dma ? dma_wdata : 16'h0000);
    chk({nm, "_cpu_gnt"}, 32'(cpu_gnt), 32'(eg_cpu));
    chk({nm, "_dma_gnt"}, 32'(dma_gnt), 32'(eg_dma));
    chk({nm, "_mem_addr"}, 32'(mem_addr), 32'(ea));
    chk({nm, "_mem_we"}, 32'(mem_we), 32'(ewe));
    chk({nm, "_mem_wdata"}, 32'(mem_wdata), 32'(ewd));
    if (eg_cpu && !cpu_we) begin e.is_dma = 1'b0; e.data = erd; sb.push_back(e); end
    if (eg_dma && !dma_we) begin e.is_dma = 1'b1; e.data = erd; sb.push_back(e); end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_rvalid || dma_rvalid) begin
        if (cpu_rvalid && dma_rvalid) chk("dual_rvalid", 32'(cpu_rvalid & dma_rvalid), 0);
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'(cpu_rvalid | dma_rvalid), 0);
        end else begin
          e = sb.pop_front();
          chk("rvalid_port_is_dma", 32'(dma_rvalid), 32'(e.is_dma));
          chk("rdata", 32'(rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h1234;
    mem[8'h01] = 16'h0101;
    mem[8'h02] = 16'h0202;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; cpu_wdata = 16'h0000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002; dma_wdata = 16'h0000;
    dma_lock = 1'b0;

    // Power-on reset with both ports requesting
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("por_cpu_gnt", 32'(cpu_gnt), 0);
      chk("por_dma_gnt", 32'(dma_gnt), 0);
      chk("por_mem_we", 32'(mem_we), 0);
      chk("por_mem_addr", 32'(mem_addr), 0);
      chk("por_rvalid", 32'({cpu_rvalid, dma_rvalid}), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "idle0");

    // CPU read of 0x0010
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step(1, 0, 16'h0010, 16'h1234, "cpu_rd");
    cpu_req = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "cpu_rd_ret");

    // Contention, both reading
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0002;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      if (i % 2 == 0) step(1, 0, 16'h0001, 16'h0101, "cont_rr");
      else            step(0, 1, 16'h0002, 16'h0202, "cont_rr");
`else
      step(1, 0, 16'h0001, 16'h0101, "cont_fix");
`endif
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "cont_end");
    step(0, 0, 16'h0000, 16'h0, "idle1");

    // Lock starvation guard: 4 locked grants, then CPU on the 5th cycle
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
    dma_addr = 16'h0030; dma_wdata = 16'h5555;
    step(0, 1, 16'h0030, 16'h0, "lock_first");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    for (int i = 0; i < 4; i++) step(0, 1, 16'h0030, 16'h0, "lock_hold");
    step(1, 0, 16'h0010, 16'h1234, "lock_cpu_wins");
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "lock_end");

    // DMA write 0xBEEF to 0x0020, CPU reads it back next cycle
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0020; dma_wdata = 16'hBEEF;
    step(0, 1, 16'h0020, 16'h0, "wr_dma");
    dma_req = 1'b0; dma_we = 1'b0; dma_wdata = 16'h0000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    step(1, 0, 16'h0020, 16'hBEEF, "rd_cpu");
    cpu_req = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "rd_ret");

    // Reset asserted mid-cycle with a read in flight; the rvalid must vanish
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    step(1, 0, 16'h0001, 16'h0101, "pre_rst");
    dma_req = 1'b1; dma_addr = 16'h0002;
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("arst_dma_gnt", 32'(dma_gnt), 0);
    chk("arst_mem_we", 32'(mem_we), 0);
    chk("arst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 0);
    sb.delete();
    step(0, 0, 16'h0000, 16'h0, "in_rst");
    step(0, 0, 16'h0000, 16'h0, "in_rst");
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "post_rst");

    cpu_req = 1'b1; cpu_addr = 16'h0010;
    step(1, 0, 16'h0010, 16'h1234, "post_rst_rd");
    cpu_req = 1'b0;
    step(0, 0, 16'h0000, 16'h0, "post_rst_ret");
    step(0, 0, 16'h0000, 16'h0, "drain");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
